// File: rtl/esm_pkg.sv
// Shared sizing and types for the ESM reorder buffer.
package esm_pkg;
   localparam int INSTR_W = 32;
   localparam int BS      = 16;
   localparam int BS_BITS = $clog2(BS);

   typedef logic [BS_BITS-1:0] tag_t;
   typedef logic [BS_BITS:0]   count_t;
endpackage

// File: rtl/esm_rob_slots.sv
// Slot storage for the reorder buffer: pending/done flags plus data words.
// Set (alloc), clear (retire) and write (completion) ports; flush wins over all.
module esm_rob_slots
   import esm_pkg::*;
#(
   parameter int INSTR_WIDTH = INSTR_W,
   parameter int SLOTS       = BS,
   parameter int TAG_W       = $clog2(SLOTS)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   set_en,
   input  logic [TAG_W-1:0]       set_idx,
   input  logic                   clr_en,
   input  logic [TAG_W-1:0]       clr_idx,
   input  logic                   wr_en,
   input  logic [TAG_W-1:0]       wr_idx,
   input  logic [INSTR_WIDTH-1:0] wr_data,
   output logic                   wr_pending,
   output logic                   wr_done,
   input  logic [TAG_W-1:0]       head_idx,
   output logic                   head_done,
   output logic [INSTR_WIDTH-1:0] head_data
);

   logic [SLOTS-1:0]       pending;
   logic [SLOTS-1:0]       done;
   logic [INSTR_WIDTH-1:0] data [SLOTS];

   // The three ports never target the same slot in one cycle: alloc hits a
   // free slot, retire hits the done head, completion needs pending && !done.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pending <= '0;
         done    <= '0;
         for (int i = 0; i < SLOTS; i++) data[i] <= '0;
      end else if (flush) begin
         pending <= '0;
         done    <= '0;
         for (int i = 0; i < SLOTS; i++) data[i] <= '0;
      end else begin
         for (int i = 0; i < SLOTS; i++) begin
            if (set_en && set_idx == TAG_W'(i)) begin
               pending[i] <= 1'b1;
               done[i]    <= 1'b0;
            end
            if (clr_en && clr_idx == TAG_W'(i)) begin
               pending[i] <= 1'b0;
               done[i]    <= 1'b0;
            end
            if (wr_en && wr_idx == TAG_W'(i)) begin
               done[i] <= 1'b1;
               data[i] <= wr_data;
            end
         end
      end
   end

   assign wr_pending = pending[wr_idx];
   assign wr_done    = done[wr_idx];
   assign head_done  = done[head_idx];
   assign head_data  = data[head_idx];

endmodule

// File: rtl/esm_reorder_buffer.sv
// Reorder buffer: hands out program-order tags, accepts out-of-order
// completions by tag and retires strictly in program order.
module esm_reorder_buffer
   import esm_pkg::*;
#(
   parameter int Instr_word_size = INSTR_W,
   parameter int bs              = BS,
   parameter int bs_bits         = $clog2(bs)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       alloc_req,
   output logic                       alloc_ready,
   output logic [bs_bits-1:0]         alloc_tag,
   input  logic                       cmp_valid,
   input  logic [bs_bits-1:0]         cmp_tag,
   input  logic [Instr_word_size-1:0] cmp_instr,
   output logic                       cmp_err,
   output logic                       retire_valid,
   input  logic                       retire_ready,
   output logic [Instr_word_size-1:0] retire_instr,
   output logic                       full,
   output logic                       empty
);

   localparam logic [bs_bits:0] FULL_COUNT = bs[bs_bits:0];

   logic [bs_bits-1:0]         head;
   logic [bs_bits-1:0]         tail;
   logic [bs_bits:0]           count;
   logic                       slot_pending;
   logic                       slot_done;
   logic                       head_done;
   logic [Instr_word_size-1:0] head_data;
   logic                       alloc_fire;
   logic                       retire_fire;
   logic                       cmp_ok;

   // Occupancy comes from count, since head == tail is ambiguous on its own.
   assign full         = (count == FULL_COUNT);
   assign empty        = (count == '0);
   assign alloc_ready  = !full;
   assign alloc_tag    = tail;
   assign retire_valid = !empty && head_done;
   assign retire_instr = retire_valid ? head_data : '0;

   assign alloc_fire  = alloc_req && !full;
   assign retire_fire = retire_valid && retire_ready;
   assign cmp_ok      = slot_pending && !slot_done;

   esm_rob_slots #(
      .INSTR_WIDTH (Instr_word_size),
      .SLOTS       (bs),
      .TAG_W       (bs_bits)
   ) u_slots (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .set_en     (alloc_fire),
      .set_idx    (tail),
      .clr_en     (retire_fire),
      .clr_idx    (head),
      .wr_en      (cmp_valid && cmp_ok),
      .wr_idx     (cmp_tag),
      .wr_data    (cmp_instr),
      .wr_pending (slot_pending),
      .wr_done    (slot_done),
      .head_idx   (head),
      .head_done  (head_done),
      .head_data  (head_data)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head    <= '0;
         tail    <= '0;
         count   <= '0;
         cmp_err <= 1'b0;
      end else if (flush) begin
         head    <= '0;
         tail    <= '0;
         count   <= '0;
         cmp_err <= 1'b0;
      end else begin
         if (alloc_fire)  tail <= tail + bs_bits'(1);
         if (retire_fire) head <= head + bs_bits'(1);
         case ({alloc_fire, retire_fire})
            2'b10:   count <= count + (bs_bits+1)'(1);
            2'b01:   count <= count - (bs_bits+1)'(1);
            default: count <= count;
         endcase
         cmp_err <= cmp_valid && !cmp_ok;
      end
   end

endmodule

// File: tb/tb_esm_reorder_buffer.sv
// Self-checking bench for esm_reorder_buffer: directed scenarios plus random
// traffic, compared against a queue-based program-order model.
module tb_esm_reorder_buffer;

   localparam int NS = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        flush = 1'b0;
   logic        alloc_req = 1'b0;
   logic        alloc_ready;
   logic [3:0]  alloc_tag;
   logic        cmp_valid = 1'b0;
   logic [3:0]  cmp_tag = '0;
   logic [31:0] cmp_instr = '0;
   logic        cmp_err;
   logic        retire_valid;
   logic        retire_ready = 1'b0;
   logic [31:0] retire_instr;
   logic        full;
   logic        empty;

   int errors = 0;
   int checks = 0;

   // Model: queue of outstanding tags in program order, per-tag done/data.
   int          q[$];
   bit          mdone [NS];
   logic [31:0] mdata [NS];
   int          mhead;
   bit          merr;

   esm_reorder_buffer dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .alloc_req    (alloc_req),
      .alloc_ready  (alloc_ready),
      .alloc_tag    (alloc_tag),
      .cmp_valid    (cmp_valid),
      .cmp_tag      (cmp_tag),
      .cmp_instr    (cmp_instr),
      .cmp_err      (cmp_err),
      .retire_valid (retire_valid),
      .retire_ready (retire_ready),
      .retire_instr (retire_instr),
      .full         (full),
      .empty        (empty)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void mreset();
      q.delete();
      for (int i = 0; i < NS; i++) begin
         mdone[i] = 1'b0;
         mdata[i] = '0;
      end
      mhead = 0;
      merr  = 1'b0;
   endfunction

   function automatic bit is_pending(input int t);
      foreach (q[i]) if (q[i] == t) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit m_rv();
      return (q.size() > 0) && mdone[q[0]];
   endfunction

   task automatic checkOutput();
      chk("alloc_ready",  32'(alloc_ready),  32'(q.size() < NS));
      chk("alloc_tag",    32'(alloc_tag),    32'((mhead + q.size()) % NS));
      chk("full",         32'(full),         32'(q.size() == NS));
      chk("empty",        32'(empty),        32'(q.size() == 0));
      chk("retire_valid", 32'(retire_valid), 32'(m_rv()));
      chk("retire_instr", retire_instr,      m_rv() ? mdata[q[0]] : 32'h0);
      chk("cmp_err",      32'(cmp_err),      32'(merr));
   endtask

   // Drive one cycle of inputs, check the current outputs, then advance the model.
   task automatic applyStimulus(input bit areq, input bit cval, input int ctag,
                                input logic [31:0] cinstr, input bit rready, input bit fl);
      bit rfire, afire, cok;
      int atag;
      alloc_req    = areq;
      cmp_valid    = cval;
      cmp_tag      = 4'(ctag);
      cmp_instr    = cinstr;
      retire_ready = rready;
      flush        = fl;
      checkOutput();
      rfire = m_rv() && rready;
      afire = areq && (q.size() < NS);
      cok   = is_pending(ctag) && !mdone[ctag];
      atag  = (mhead + q.size()) % NS;
      @(posedge clk);
      if (fl) begin
         mreset();
      end else begin
         if (cval && cok) begin
            mdone[ctag] = 1'b1;
            mdata[ctag] = cinstr;
         end
         if (rfire) begin
            mdone[q[0]] = 1'b0;
            void'(q.pop_front());
            mhead = (mhead + 1) % NS;
         end
         if (afire) begin
            q.push_back(atag);
            mdone[atag] = 1'b0;
         end
         merr = cval && !cok;
      end
      #1;
   endtask

   task automatic idle(input bit rready);
      applyStimulus(1'b0, 1'b0, 0, 32'h0, rready, 1'b0);
   endtask

   task automatic doFlush();
      applyStimulus(1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b1);
   endtask

   initial begin
      int t;
      mreset();
      #2;
      checkOutput();
      @(posedge clk); #1;
      rst = 1'b1;
      checkOutput();

      // In-order retire of out-of-order completions
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 0, 32'h0, 1'b1, 1'b0);
      chk("tag_after3", 32'(alloc_tag), 32'd3);
      applyStimulus(1'b0, 1'b1, 2, 32'hA2, 1'b1, 1'b0);
      chk("rv_before_head_done", 32'(retire_valid), 32'd0);
      applyStimulus(1'b0, 1'b1, 0, 32'hA0, 1'b1, 1'b0);
      chk("head_A0", retire_instr, 32'hA0);
      applyStimulus(1'b0, 1'b1, 1, 32'hA1, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) idle(1'b1);

      // Fill, refuse alloc while full, even alongside a retire
      doFlush();
      for (int i = 0; i < NS; i++) applyStimulus(1'b1, 1'b0, 0, 32'h0, 1'b0, 1'b0);
      chk("full_after16", 32'(full), 32'd1);
      applyStimulus(1'b1, 1'b0, 0, 32'h0, 1'b0, 1'b0);
      chk("tail_after17", 32'(alloc_tag), 32'd0);
      applyStimulus(1'b0, 1'b1, 0, 32'h55, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 0, 32'h0, 1'b1, 1'b0);
      chk("full_after_refused", 32'(full), 32'd0);
      applyStimulus(1'b1, 1'b0, 0, 32'h0, 1'b0, 1'b0);
      chk("full_after_realloc", 32'(full), 32'd1);

      // Completion errors and a stalled retire
      doFlush();
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 0, 32'h0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 5, 32'hBAD5, 1'b0, 1'b0);
      chk("err_unalloc", 32'(cmp_err), 32'd1);
      applyStimulus(1'b0, 1'b1, 0, 32'h11, 1'b0, 1'b0);
      chk("err_pulse_end", 32'(cmp_err), 32'd0);
      applyStimulus(1'b0, 1'b1, 0, 32'h22, 1'b0, 1'b0);
      chk("err_redone", 32'(cmp_err), 32'd1);
      chk("data_kept", retire_instr, 32'h11);
      applyStimulus(1'b0, 1'b1, 1, 32'h33, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 2, 32'h44, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) idle(1'b0);
      for (int i = 0; i < 4; i++) idle(1'b1);

      // Wrap-around with steady alloc/complete/retire
      doFlush();
      for (int i = 0; i < 40; i++) begin
         if (q.size() > 0 && !mdone[q[q.size()-1]])
            applyStimulus(1'b1, 1'b1, q[q.size()-1], $urandom, 1'b1, 1'b0);
         else
            applyStimulus(1'b1, 1'b0, 0, 32'h0, 1'b1, 1'b0);
      end
      for (int i = 0; i < 6; i++) begin
         t = -1;
         foreach (q[k]) if (t < 0 && !mdone[q[k]]) t = q[k];
         if (t >= 0) applyStimulus(1'b0, 1'b1, t, $urandom, 1'b1, 1'b0);
         else        idle(1'b1);
      end
      chk("wrap_empty", 32'(empty), 32'd1);

      // Flush with outstanding slots and a same-cycle completion
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 0, 32'h0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, q[0], 32'hC0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, q[2], 32'hDEAD, 1'b1, 1'b1);
      chk("flush_empty", 32'(empty), 32'd1);
      chk("flush_tag0",  32'(alloc_tag), 32'd0);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         bit cv;
         int ct;
         cv = ($urandom_range(0, 2) != 0);
         if (q.size() > 0 && $urandom_range(0, 7) != 0) ct = q[$urandom_range(0, q.size()-1)];
         else                                           ct = $urandom_range(0, NS-1);
         applyStimulus($urandom_range(0, 9) < 6, cv, ct, $urandom,
                       $urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0);
      end

      // Asynchronous reset in the middle of traffic
      for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 0, 32'h0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, q[1], 32'h77, 1'b0, 1'b0);
      alloc_req = 1'b0; cmp_valid = 1'b0; retire_ready = 1'b0; flush = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      mreset();
      checkOutput();
      @(posedge clk); #1;
      checkOutput();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 0, 32'h0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 0, 32'h99, 1'b1, 1'b0);
      idle(1'b1);
      idle(1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
